// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Data accesses win by default; a saturating starvation counter forces fetch through.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [XLEN-1:0] if_data,
  input  logic            flush,

  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_valid,
  output logic [XLEN-1:0] ls_rdata,

  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t          owner_q, owner_d;
  logic            store_q, store_d;
  logic [3:0]      starve_q, starve_d;
  logic [XLEN-1:0] if_hold_q, if_hold_d;
  logic [XLEN-1:0] ls_hold_q, ls_hold_d;

  logic            if_sel;
  logic            ls_sel;
  logic            ls_load;

  // Raw selection ignores reset; only the externally visible grants and the
  // write enable are masked so a store during reset never reaches the RAM.
  always_comb begin
    if_sel = if_req && (!ls_req || (starve_q == LIMIT));
    ls_sel = ls_req && !if_sel;
    if_gnt = if_sel && rst;
    ls_gnt = ls_sel && rst;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (if_sel) begin
      mem_addr = if_addr;
    end else if (ls_sel) begin
      mem_addr  = ls_addr;
      mem_we    = ls_we && rst;
      mem_wdata = ls_wdata;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (if_req && ls_sel) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
  end

  // A fetch granted together with flush is tracked as no owner, so its
  // returning read data is never presented.
  always_comb begin
    owner_d = OWN_NONE;
    store_d = 1'b0;
    if (if_sel) begin
      owner_d = flush ? OWN_NONE : OWN_IF;
    end else if (ls_sel) begin
      owner_d = OWN_LS;
      store_d = ls_we;
    end
  end

  always_comb begin
    if_valid  = (owner_q == OWN_IF) && !flush;
    ls_valid  = (owner_q == OWN_LS);
    ls_load   = ls_valid && !store_q;
    if_data   = if_valid ? mem_rdata : if_hold_q;
    ls_rdata  = ls_load  ? mem_rdata : ls_hold_q;
    if_hold_d = if_data;
    ls_hold_d = ls_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      store_q   <= 1'b0;
      starve_q  <= 4'd0;
      if_hold_q <= '0;
      ls_hold_q <= '0;
    end else begin
      owner_q   <= owner_d;
      store_q   <= store_d;
      starve_q  <= starve_d;
      if_hold_q <= if_hold_d;
      ls_hold_q <= ls_hold_d;
    end
  end

endmodule
